// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 3;
    localparam int RF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    // last=1 means requester 1 won most recently, so requester 0 takes the tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between two requesters with round-robin
// arbitration and optional locked bursts; the write stage is registered.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int MAX_BURST  = RF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  lock0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt1,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   last_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic                   pick0;
    logic                   pick1;
    logic                   xfer;
    logic                   lock_win;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   at_max;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    // While a burst owner exists the other requester is stalled outright
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: ;
        endcase
    end

    assign xfer     = gnt0 | gnt1;
    assign lock_win = gnt1 ? lock1 : lock0;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign at_max   = (cnt_inc == CNT_W'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer;
            if (xfer) begin
                addr_q  <= gnt1 ? addr1 : addr0;
                wdata_q <= gnt1 ? din1 : din0;
                last_q  <= gnt1;
            end
            unique case (state_q)
                IDLE: begin
                    if (xfer && lock_win && (MAX_BURST > 1)) begin
                        state_q <= gnt1 ? OWN1 : OWN0;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                OWN0, OWN1: begin
                    // Owner dropping its request, unlocking or hitting the cap all release
                    if (!xfer || !lock_win || at_max) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign we    = we_q;
    assign Addr  = addr_q;
    assign wdata = wdata_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, a same-address
// sequence, and randomized traffic against an owner/run-length reference model.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, lock0, req1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1, we, busy;
    logic [AW-1:0] Addr;
    logic [DW-1:0] wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .lock0 (lock0),
        .addr0 (addr0),
        .din0  (din0),
        .gnt0  (gnt0),
        .req1  (req1),
        .lock1 (lock1),
        .addr1 (addr1),
        .din1  (din1),
        .gnt1  (gnt1),
        .we    (we),
        .Addr  (Addr),
        .wdata (wdata),
        .busy  (busy)
    );

    typedef struct {
        logic          rst;
        logic          r0;
        logic          l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0;
        logic          g1;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic g0, input logic g1, input logic e_we, input logic [AW-1:0] e_addr,
        input logic [DW-1:0] e_data, input logic e_busy);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = e_we; v.addr = e_addr; v.data = e_data; v.busy = e_busy;
        return v;
    endfunction

    // Reference model: who owns the port (-1 = nobody), how long the current run is,
    // who won last, and what the write stage should show after the edge.
    int            m_own  = -1;
    int            m_run  = 0;
    bit            m_last = 1'b1;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_g0, m_g1;

    task automatic model_step();
        int win;
        if (m_own == 0)      win = req0 ? 0 : -1;
        else if (m_own == 1) win = req1 ? 1 : -1;
        else if (req0 && req1) win = m_last ? 0 : 1;
        else if (req0)       win = 0;
        else if (req1)       win = 1;
        else                 win = -1;
        m_g0 = (win == 0);
        m_g1 = (win == 1);
        if (reset) begin
            m_own = -1; m_run = 0; m_last = 1'b1;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else if (win >= 0) begin
            m_we   = 1'b1;
            m_addr = (win == 0) ? addr0 : addr1;
            m_data = (win == 0) ? din0 : din1;
            m_last = (win == 1);
            m_run  = (m_own == win) ? m_run + 1 : 1;
            if (((win == 0) ? lock0 : lock1) && m_run < MB) m_own = win;
            else begin m_own = -1; m_run = 0; end
        end else begin
            m_we  = 1'b0;
            m_own = -1;
            m_run = 0;
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic          o_g0, o_g1, o_we, o_busy;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    // Drive one cycle of inputs (called just after a falling edge), sample grants
    // before the rising edge and the registered outputs just after it.
    task automatic apply(input vec_t v);
        reset = v.rst;
        req0 = v.r0; lock0 = v.l0; addr0 = v.a0; din0 = v.d0;
        req1 = v.r1; lock1 = v.l1; addr1 = v.a1; din1 = v.d1;
        #1;
        o_g0 = gnt0;
        o_g1 = gnt1;
        model_step();
        @(posedge clk);
        #1;
        o_we = we; o_addr = Addr; o_data = wdata; o_busy = busy;
        @(negedge clk);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, " gnt0"},  DW'(o_g0),   DW'(v.g0));
        chk({tag, " gnt1"},  DW'(o_g1),   DW'(v.g1));
        chk({tag, " we"},    DW'(o_we),   DW'(v.we));
        chk({tag, " Addr"},  DW'(o_addr), DW'(v.addr));
        chk({tag, " wdata"}, o_data,      v.data);
        chk({tag, " busy"},  DW'(o_busy), DW'(v.busy));
    endtask

    vec_t tbl[24];
    vec_t v;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; lock0 = 1'b0; addr0 = '0; din0 = '0;
        req1 = 1'b0; lock1 = 1'b0; addr1 = '0; din1 = '0;
        o_g0 = 1'b0; o_g1 = 1'b0; o_we = 1'b0; o_busy = 1'b0; o_addr = '0; o_data = '0;

        //             rst r0 l0 a0 d0            r1 l1 a1 d1            g0 g1 we addr data          busy
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
        tbl[4]  = mk(0, 1, 0, 3, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        1, 0, 1, 3, 32'hA5A5A5A5, 0);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 3, 32'hA5A5A5A5, 0);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 5, 32'h55555555, 0, 1, 1, 5, 32'h55555555, 0);
        tbl[7]  = mk(0, 1, 0, 1, 32'h11111111, 1, 0, 2, 32'h22222222, 1, 0, 1, 1, 32'h11111111, 0);
        tbl[8]  = mk(0, 1, 0, 1, 32'h11111111, 1, 0, 2, 32'h22222222, 0, 1, 1, 2, 32'h22222222, 0);
        tbl[9]  = mk(0, 1, 0, 1, 32'h11111111, 1, 0, 2, 32'h22222222, 1, 0, 1, 1, 32'h11111111, 0);
        tbl[10] = mk(0, 1, 0, 1, 32'h11111111, 1, 0, 2, 32'h22222222, 0, 1, 1, 2, 32'h22222222, 0);
        tbl[11] = mk(0, 1, 1, 4, 32'h44444444, 1, 0, 6, 32'h66666666, 1, 0, 1, 4, 32'h44444444, 1);
        tbl[12] = mk(0, 1, 1, 4, 32'h44444444, 1, 0, 6, 32'h66666666, 1, 0, 1, 4, 32'h44444444, 1);
        tbl[13] = mk(0, 1, 1, 4, 32'h44444444, 1, 0, 6, 32'h66666666, 1, 0, 1, 4, 32'h44444444, 1);
        tbl[14] = mk(0, 1, 1, 4, 32'h44444444, 1, 0, 6, 32'h66666666, 1, 0, 1, 4, 32'h44444444, 0);
        tbl[15] = mk(0, 1, 1, 4, 32'h44444444, 1, 0, 6, 32'h66666666, 0, 1, 1, 6, 32'h66666666, 0);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        1, 1, 7, 32'h77777777, 0, 1, 1, 7, 32'h77777777, 1);
        tbl[17] = mk(0, 1, 0, 2, 32'h12345678, 1, 1, 7, 32'h77777777, 0, 1, 1, 7, 32'h77777777, 1);
        tbl[18] = mk(1, 1, 0, 2, 32'h12345678, 1, 1, 7, 32'h77777777, 0, 1, 0, 0, 32'h0,        0);
        tbl[19] = mk(0, 1, 0, 2, 32'h12345678, 1, 0, 7, 32'h77777777, 1, 0, 1, 2, 32'h12345678, 0);
        tbl[20] = mk(0, 1, 1, 3, 32'h33333333, 0, 0, 0, 32'h0,        1, 0, 1, 3, 32'h33333333, 1);
        tbl[21] = mk(0, 0, 0, 0, 32'h0,        1, 0, 5, 32'h5A5A5A5A, 0, 0, 0, 3, 32'h33333333, 0);
        tbl[22] = mk(0, 0, 0, 0, 32'h0,        1, 0, 5, 32'h5A5A5A5A, 0, 1, 1, 5, 32'h5A5A5A5A, 0);
        tbl[23] = mk(0, 0, 1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0, 5, 32'h5A5A5A5A, 0);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            apply(tbl[i]);
            chk_vec($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Both requesters hit the same register in one cycle: the loser writes next, so its data sticks.
        apply(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        v = mk(0, 1, 0, 6, 32'hAAAAAAAA, 1, 0, 6, 32'hBBBBBBBB, 1, 0, 1, 6, 32'hAAAAAAAA, 0);
        apply(v);
        chk_vec("same_addr first", v);
        v.g0 = 1'b0; v.g1 = 1'b1; v.data = 32'hBBBBBBBB;
        apply(v);
        chk_vec("same_addr second", v);
        v = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 6, 32'hBBBBBBBB, 0);
        apply(v);
        chk_vec("same_addr settle", v);

        // Randomized traffic against the reference model
        apply(mk(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < 600; i++) begin
            v = mk($urandom_range(63) == 0,
                   $urandom_range(3) != 0, $urandom_range(1) == 1, AW'($urandom_range(7)), $urandom,
                   $urandom_range(3) != 0, $urandom_range(1) == 1, AW'($urandom_range(7)), $urandom,
                   0, 0, 0, 0, 32'h0, 0);
            apply(v);
            v.g0 = m_g0; v.g1 = m_g1; v.we = m_we; v.addr = m_addr; v.data = m_data;
            v.busy = (m_own >= 0);
            chk_vec($sformatf("rand[%0d]", i), v);
            if (o_g0 && o_g1) begin
                n_err++;
                $display("FAIL rand[%0d] both grants: got 11, expected at most one", i);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
